// File: rtl/cpu_sequencer_if.sv
// SM83 sequencer bundle: decoder control word, ALU operands and memory port.
interface cpu_sequencer_if;
  logic [7:0]  opcode;
  logic [2:0]  step;
  logic        done;
  logic        is_cond;
  logic [2:0]  next_cond;
  logic [2:0]  s_ab;
  logic [3:0]  s_db;
  logic [3:0]  t_db;
  logic        use_alu;
  logic [1:0]  s_acc;
  logic        idu;
  logic        wr_pc;
  logic        write_mem;
  logic        cond_met;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_result;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        halted;

  modport master (
    output opcode, step, alu_a, alu_b,
    output mem_addr, mem_wdata, mem_we, halted,
    input  done, is_cond, next_cond,
    input  s_ab, s_db, t_db, use_alu, s_acc,
    input  idu, wr_pc, write_mem, cond_met,
    input  alu_result, mem_rdata, mem_ready
  );

  modport slave (
    input  opcode, step, alu_a, alu_b,
    input  mem_addr, mem_wdata, mem_we, halted,
    output done, is_cond, next_cond,
    output s_ab, s_db, t_db, use_alu, s_acc,
    output idu, wr_pc, write_mem, cond_met,
    output alu_result, mem_rdata, mem_ready
  );
endinterface

// File: rtl/cpu_sequencer.sv
// SM83 execution sequencer: IR, step counter, register file,
// address/data bus muxes, IDU and memory port.
module cpu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] RESET_SP = 16'hFFFE
) (
  input  logic           clk,
  input  logic           reset,
  cpu_sequencer_if.master bus
);
  localparam logic [3:0] R_A   = 4'd0;
  localparam logic [3:0] R_B   = 4'd1;
  localparam logic [3:0] R_C   = 4'd2;
  localparam logic [3:0] R_D   = 4'd3;
  localparam logic [3:0] R_E   = 4'd4;
  localparam logic [3:0] R_H   = 4'd5;
  localparam logic [3:0] R_L   = 4'd6;
  localparam logic [3:0] R_W   = 4'd7;
  localparam logic [3:0] R_Z   = 4'd8;
  localparam logic [3:0] R_PCH = 4'd9;
  localparam logic [3:0] R_PCL = 4'd10;
  localparam logic [3:0] R_SPH = 4'd11;
  localparam logic [3:0] R_SPL = 4'd12;
  localparam logic [3:0] R_MEM = 4'd13;

  localparam logic [2:0] AB_WZ = 3'd0;
  localparam logic [2:0] AB_BC = 3'd1;
  localparam logic [2:0] AB_DE = 3'd2;
  localparam logic [2:0] AB_HL = 3'd3;
  localparam logic [2:0] AB_SP = 3'd4;

  localparam logic [1:0] ACC_SPL = 2'd1;
  localparam logic [1:0] ACC_SPH = 2'd2;
  localparam logic [1:0] ACC_PCL = 2'd3;

  localparam logic IDU_DEC = 1'b1;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    HALT
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      pc_q, pc_d;
  logic [15:0]      sp_q, sp_d;
  logic [7:0]       ir_q, ir_d;
  logic [2:0]       step_q, step_d;
  logic             halted_q, halted_d;
  logic [8:0][7:0]  rf_q, rf_d;

  logic [15:0] ab;
  logic [15:0] idu_out;
  logic [7:0]  db_in;
  logic [7:0]  db_out;
  logic        exec;
  logic        mem_we;
  logic        reg_we;

  assign exec = (state_q == EXEC);

  always_comb begin
    ab = pc_q;
    if (exec) begin
      case (bus.s_ab)
        AB_WZ:   ab = {rf_q[R_W], rf_q[R_Z]};
        AB_BC:   ab = {rf_q[R_B], rf_q[R_C]};
        AB_DE:   ab = {rf_q[R_D], rf_q[R_E]};
        AB_HL:   ab = {rf_q[R_H], rf_q[R_L]};
        AB_SP:   ab = sp_q;
        default: ab = pc_q;
      endcase
    end
  end

  always_comb begin
    db_in = 8'h00;
    case (bus.s_db)
      R_A, R_B, R_C, R_D, R_E,
      R_H, R_L, R_W, R_Z: db_in = rf_q[bus.s_db];
      R_PCH:              db_in = pc_q[15:8];
      R_PCL:              db_in = pc_q[7:0];
      R_SPH:              db_in = sp_q[15:8];
      R_SPL:              db_in = sp_q[7:0];
      R_MEM:              db_in = bus.mem_rdata;
      default:            db_in = 8'h00;
    endcase
  end

  assign db_out  = bus.use_alu ? bus.alu_result : db_in;
  assign idu_out = (bus.idu == IDU_DEC) ? ab - 16'd1 : ab + 16'd1;

  // A store cycle owns the data bus, so it never also writes a register.
  assign mem_we = exec & (bus.write_mem |
                  ((bus.t_db == R_MEM) & (bus.s_db != R_MEM)));
  assign reg_we = exec & (bus.t_db != R_MEM) & ~mem_we;

  always_comb begin
    bus.alu_a = rf_q[R_A];
    case (bus.s_acc)
      ACC_SPL: bus.alu_a = sp_q[7:0];
      ACC_SPH: bus.alu_a = sp_q[15:8];
      ACC_PCL: bus.alu_a = pc_q[7:0];
      default: bus.alu_a = rf_q[R_A];
    endcase
  end

  assign bus.alu_b     = db_in;
  assign bus.mem_addr  = ab;
  assign bus.mem_wdata = db_in;
  assign bus.mem_we    = mem_we;
  assign bus.opcode    = ir_q;
  assign bus.step      = step_q;
  assign bus.halted    = halted_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    sp_d     = sp_q;
    ir_d     = ir_q;
    step_d   = step_q;
    halted_d = halted_q;
    rf_d     = rf_q;
    case (state_q)
      FETCH: begin
        if (bus.mem_ready) begin
          ir_d    = bus.mem_rdata;
          pc_d    = pc_q + 16'd1;
          step_d  = 3'd0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (bus.mem_ready) begin
          if (reg_we) begin
            case (bus.t_db)
              R_PCH:   pc_d[15:8] = db_out;
              R_PCL:   pc_d[7:0]  = db_out;
              R_SPH:   sp_d[15:8] = db_out;
              R_SPL:   sp_d[7:0]  = db_out;
              R_A, R_B, R_C, R_D, R_E,
              R_H, R_L, R_W, R_Z: rf_d[bus.t_db] = db_out;
              default: ;
            endcase
          end
          if (bus.wr_pc) pc_d = idu_out;
          if (bus.done) begin
            ir_d   = bus.mem_rdata;
            step_d = 3'd0;
          end else if (bus.is_cond && !bus.cond_met) begin
            step_d = bus.next_cond;
          end else if (step_q == 3'd7) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      sp_q     <= RESET_SP;
      ir_q     <= 8'h00;
      step_q   <= 3'd0;
      halted_q <= 1'b0;
      rf_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      ir_q     <= ir_d;
      step_q   <= step_d;
      halted_q <= halted_d;
      rf_q     <= rf_d;
    end
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed vector table plus randomized
// control words checked against a behavioural machine model.
module tb_cpu_sequencer;
  localparam logic [3:0] R_A = 0, R_B = 1, R_H = 5, R_L = 6;
  localparam logic [3:0] R_W = 7, R_Z = 8, R_PCH = 9, R_PCL = 10;
  localparam logic [3:0] R_SPH = 11, R_SPL = 12, R_MEM = 13;
  localparam logic [2:0] P_WZ = 0, P_HL = 3, P_PC = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_sequencer_if bus();

  cpu_sequencer #(
    .RESET_PC(16'h0000),
    .RESET_SP(16'hFFFE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_run = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  s_ab;
    logic [3:0]  s_db, t_db;
    logic        use_alu;
    logic [1:0]  s_acc;
    logic        idu, wr_pc, wm, done, isc, cm;
    logic [2:0]  nc;
    logic [7:0]  rd, res;
    logic        rdy;
    logic [15:0] e_addr;
    logic        e_we;
    logic [7:0]  e_wd;
    logic [2:0]  e_step;
    int          pk;
    logic [3:0]  psel;
    logic [15:0] pexp;
  } vec_t;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [2:0] ab, input logic [3:0] sdb, input logic [3:0] tdb,
    input logic wp, input logic dec, input logic wm, input logic dn,
    input logic [7:0] rd, input logic [15:0] ea, input logic ewe,
    input logic [7:0] ewd, input logic [2:0] est);
    vec_t v;
    v.s_ab = ab; v.s_db = sdb; v.t_db = tdb;
    v.use_alu = 1'b0; v.s_acc = 2'd0;
    v.idu = dec; v.wr_pc = wp; v.wm = wm; v.done = dn;
    v.isc = 1'b0; v.cm = 1'b0; v.nc = 3'd0;
    v.rd = rd; v.res = 8'h00; v.rdy = 1'b1;
    v.e_addr = ea; v.e_we = ewe; v.e_wd = ewd; v.e_step = est;
    v.pk = 0; v.psel = 4'd0; v.pexp = 16'h0;
    return v;
  endfunction

  function automatic vec_t pr(input vec_t vi, input int k,
                              input logic [3:0] s, input logic [15:0] e);
    vec_t v;
    v = vi;
    v.pk = k; v.psel = s; v.pexp = e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.s_ab = v.s_ab; bus.s_db = v.s_db; bus.t_db = v.t_db;
    bus.use_alu = v.use_alu; bus.s_acc = v.s_acc;
    bus.idu = v.idu; bus.wr_pc = v.wr_pc; bus.write_mem = v.wm;
    bus.done = v.done; bus.is_cond = v.isc; bus.cond_met = v.cm;
    bus.next_cond = v.nc; bus.mem_rdata = v.rd;
    bus.alu_result = v.res; bus.mem_ready = v.rdy;
  endtask

  // Probes use a stalled cycle, so they observe without disturbing state.
  task automatic probe(input int k, input logic [3:0] s,
                       input logic [15:0] e, input string nm);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    bus.use_alu = 1'b0;
    case (k)
      1: bus.s_db = s;
      2: bus.s_ab = s[2:0];
      3: bus.s_acc = s[1:0];
      default: ;
    endcase
    #1;
    case (k)
      1: chk({nm, " reg"}, {8'h00, bus.alu_b}, e);
      2: chk({nm, " pair"}, bus.mem_addr, e);
      3: chk({nm, " alu_a"}, {8'h00, bus.alu_a}, e);
      4: chk({nm, " opcode"}, {8'h00, bus.opcode}, e);
      default: chk({nm, " halted"}, {15'h0, bus.halted}, e);
    endcase
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    @(negedge clk);
    drive(v);
    #1;
    chk({nm, " addr"}, bus.mem_addr, v.e_addr);
    chk({nm, " we"}, {15'h0, bus.mem_we}, {15'h0, v.e_we});
    chk({nm, " wdata"}, {8'h00, bus.mem_wdata}, {8'h00, v.e_wd});
    chk({nm, " alu_b"}, {8'h00, bus.alu_b}, {8'h00, v.e_wd});
    @(posedge clk);
    #1;
    chk({nm, " step"}, {13'h0, bus.step}, {13'h0, v.e_step});
    if (v.pk != 0) probe(v.pk, v.psel, v.pexp, nm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [7:0]  mr [0:8];
  logic [15:0] mpc, msp;
  logic [7:0]  mir;
  int          mstep, mmode;
  logic        mhalt;

  function automatic void minit();
    for (int i = 0; i < 9; i++) mr[i] = 8'h00;
    mpc = 16'h0000; msp = 16'hFFFE; mir = 8'h00;
    mstep = 0; mmode = 0; mhalt = 1'b0;
  endfunction

  function automatic logic [7:0] m_db(input logic [3:0] s,
                                      input logic [7:0] rd);
    if (s <= 4'd8) return mr[s];
    case (s)
      R_PCH: return mpc[15:8];
      R_PCL: return mpc[7:0];
      R_SPH: return msp[15:8];
      R_SPL: return msp[7:0];
      R_MEM: return rd;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [15:0] m_addr(input logic [2:0] s);
    if (mmode != 1) return mpc;
    case (s)
      3'd0: return {mr[7], mr[8]};
      3'd1: return {mr[1], mr[2]};
      3'd2: return {mr[3], mr[4]};
      3'd3: return {mr[5], mr[6]};
      3'd4: return msp;
      default: return mpc;
    endcase
  endfunction

  function automatic void m_write(input logic [3:0] t, input logic [7:0] d);
    if (t <= 4'd8) mr[t] = d;
    else if (t == R_PCH) mpc[15:8] = d;
    else if (t == R_PCL) mpc[7:0] = d;
    else if (t == R_SPH) msp[15:8] = d;
    else if (t == R_SPL) msp[7:0] = d;
  endfunction

  vec_t tv[$];
  vec_t v;

  initial begin
    reset = 1'b1;
    v = mk(P_PC, R_MEM, R_MEM, 0, 0, 0, 0, 8'h00, 16'h0, 0, 8'h00, 3'd0);
    drive(v);
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    bus.write_mem = 1'b1;
    #1;
    chk("rst addr", bus.mem_addr, 16'h0000);
    chk("rst we", {15'h0, bus.mem_we}, 16'h0);
    chk("rst step", {13'h0, bus.step}, 16'h0);
    chk("rst opcode", {8'h00, bus.opcode}, 16'h0);
    chk("rst halted", {15'h0, bus.halted}, 16'h0);
    probe(1, R_SPH, 16'h00FF, "rst sph");
    probe(1, R_SPL, 16'h00FE, "rst spl");
    probe(1, R_A, 16'h0000, "rst a");

    tv.push_back(pr(mk(P_PC, R_MEM, R_MEM, 0, 0, 0, 0, 8'h3E,
                       16'h0000, 0, 8'h3E, 3'd0), 4, 0, 16'h003E));
    tv.push_back(mk(P_PC, R_MEM, R_Z, 1, 0, 0, 0, 8'h5A,
                    16'h0001, 0, 8'h5A, 3'd1));
    tv.push_back(pr(mk(P_PC, R_Z, R_A, 1, 0, 0, 1, 8'h77,
                       16'h0002, 0, 8'h5A, 3'd0), 4, 0, 16'h0077));
    tv.push_back(pr(mk(P_PC, R_MEM, R_H, 0, 0, 0, 0, 8'hC0,
                       16'h0003, 0, 8'hC0, 3'd1), 2, P_PC, 16'h0003));
    tv.push_back(pr(mk(P_PC, R_MEM, R_L, 0, 0, 0, 0, 8'h00,
                       16'h0003, 0, 8'h00, 3'd2), 1, R_A, 16'h005A));
    tv.push_back(pr(mk(P_PC, R_MEM, R_A, 1, 0, 0, 1, 8'h77,
                       16'h0003, 0, 8'h77, 3'd0), 1, R_H, 16'h00C0));
    tv.push_back(pr(mk(P_HL, R_A, R_MEM, 0, 0, 0, 0, 8'h11,
                       16'hC000, 1, 8'h77, 3'd1), 2, P_HL, 16'hC000));
    tv.push_back(pr(mk(P_PC, R_MEM, R_MEM, 1, 0, 0, 1, 8'hEA,
                       16'h0004, 0, 8'hEA, 3'd0), 4, 0, 16'h00EA));
    tv.push_back(pr(mk(P_PC, R_MEM, R_Z, 1, 0, 0, 0, 8'h23,
                       16'h0005, 0, 8'h23, 3'd1), 1, R_A, 16'h0077));
    tv.push_back(pr(mk(P_PC, R_MEM, R_W, 1, 0, 0, 0, 8'hD1,
                       16'h0006, 0, 8'hD1, 3'd2), 2, P_WZ, 16'hD123));
    tv.push_back(pr(mk(P_WZ, R_A, R_MEM, 0, 0, 0, 0, 8'h00,
                       16'hD123, 1, 8'h77, 3'd3), 1, R_A, 16'h0077));
    v = mk(P_WZ, R_A, R_MEM, 1, 0, 1, 0, 8'h00, 16'hD123, 1, 8'h77, 3'd3);
    v.rdy = 1'b0;
    v = pr(v, 2, P_PC, 16'h0007);
    repeat (3) tv.push_back(v);
    v = mk(P_PC, R_MEM, R_B, 0, 0, 0, 0, 8'h99, 16'h0007, 0, 8'h99, 3'd3);
    v.rdy = 1'b0;
    tv.push_back(pr(v, 1, R_B, 16'h0000));
    tv.push_back(pr(mk(P_WZ, R_A, R_MEM, 0, 0, 1, 0, 8'h00,
                       16'hD123, 1, 8'h77, 3'd4), 2, P_PC, 16'h0007));
    tv.push_back(pr(mk(P_PC, R_MEM, R_MEM, 1, 0, 0, 1, 8'h00,
                       16'h0007, 0, 8'h00, 3'd0), 2, P_PC, 16'h0008));
    tv.push_back(pr(mk(P_PC, R_MEM, R_MEM, 0, 0, 0, 0, 8'h00,
                       16'h0008, 0, 8'h00, 3'd1), 3, 0, 16'h0077));
    v = mk(P_PC, R_MEM, R_MEM, 0, 0, 0, 0, 8'h00, 16'h0008, 0, 8'h00, 3'd5);
    v.isc = 1'b1; v.cm = 1'b0; v.nc = 3'd5;
    tv.push_back(pr(v, 3, 1, 16'h00FE));
    tv.push_back(pr(mk(P_PC, R_MEM, R_MEM, 0, 0, 0, 1, 8'h00,
                       16'h0008, 0, 8'h00, 3'd0), 3, 2, 16'h00FF));
    tv.push_back(pr(mk(P_PC, R_MEM, R_MEM, 0, 0, 0, 0, 8'h00,
                       16'h0008, 0, 8'h00, 3'd1), 3, 3, 16'h0008));
    v = mk(P_PC, R_MEM, R_MEM, 0, 0, 0, 0, 8'h00, 16'h0008, 0, 8'h00, 3'd2);
    v.isc = 1'b1; v.cm = 1'b1; v.nc = 3'd5;
    tv.push_back(v);
    v = mk(P_PC, R_MEM, R_MEM, 0, 0, 0, 1, 8'h00, 16'h0008, 0, 8'h00, 3'd0);
    v.isc = 1'b1; v.cm = 1'b0; v.nc = 3'd5;
    tv.push_back(v);
    v = mk(P_PC, R_A, R_B, 0, 0, 0, 0, 8'h00, 16'h0008, 0, 8'h77, 3'd1);
    v.use_alu = 1'b1; v.res = 8'h3C;
    tv.push_back(pr(v, 1, R_B, 16'h003C));
    tv.push_back(mk(P_PC, R_MEM, R_PCH, 0, 0, 0, 0, 8'hFF,
                    16'h0008, 0, 8'hFF, 3'd2));
    tv.push_back(pr(mk(P_PC, R_MEM, R_PCL, 0, 0, 0, 0, 8'hFF,
                       16'hFF08, 0, 8'hFF, 3'd3), 2, P_PC, 16'hFFFF));
    tv.push_back(pr(mk(P_PC, R_MEM, R_MEM, 1, 0, 0, 0, 8'h00,
                       16'hFFFF, 0, 8'h00, 3'd4), 2, P_PC, 16'h0000));
    tv.push_back(pr(mk(P_PC, R_MEM, R_PCL, 1, 1, 0, 0, 8'h55,
                       16'h0000, 0, 8'h55, 3'd5), 2, P_PC, 16'hFFFF));
    tv.push_back(pr(mk(P_PC, R_MEM, R_MEM, 0, 0, 0, 0, 8'h00,
                       16'hFFFF, 0, 8'h00, 3'd6), 5, 0, 16'h0000));
    tv.push_back(pr(mk(P_PC, R_MEM, R_MEM, 0, 0, 0, 0, 8'h00,
                       16'hFFFF, 0, 8'h00, 3'd7), 5, 0, 16'h0000));
    tv.push_back(pr(mk(P_PC, R_MEM, R_MEM, 0, 0, 0, 0, 8'h00,
                       16'hFFFF, 0, 8'h00, 3'd7), 5, 0, 16'h0001));
    v = mk(P_WZ, R_A, R_MEM, 0, 0, 1, 1, 8'h00, 16'hFFFF, 0, 8'h77, 3'd7);
    tv.push_back(pr(v, 5, 0, 16'h0001));

    for (int i = 0; i < tv.size(); i++)
      run_vec(tv[i], $sformatf("v%0d", i));

    do_reset();
    probe(5, 0, 16'h0000, "rst2");
    run_vec(pr(mk(P_PC, R_MEM, R_MEM, 0, 0, 0, 0, 8'h12,
                  16'h0000, 0, 8'h12, 3'd0), 4, 0, 16'h0012), "mid0");
    run_vec(pr(mk(P_PC, R_MEM, R_SPH, 0, 0, 0, 0, 8'h12,
                  16'h0001, 0, 8'h12, 3'd1), 1, R_SPH, 16'h0012), "mid1");
    run_vec(mk(P_PC, R_MEM, R_PCH, 0, 0, 0, 0, 8'h40,
               16'h0001, 0, 8'h40, 3'd2), "mid2");
    do_reset();
    @(negedge clk);
    #1;
    chk("mid addr", bus.mem_addr, 16'h0000);
    chk("mid step", {13'h0, bus.step}, 16'h0);
    chk("mid opcode", {8'h00, bus.opcode}, 16'h0);
    probe(1, R_SPH, 16'h00FF, "mid sph");
    probe(1, R_SPL, 16'h00FE, "mid spl");
    run_vec(pr(mk(P_HL, R_A, R_MEM, 0, 0, 1, 0, 8'hAB,
                  16'h0000, 0, 8'h00, 3'd0), 4, 0, 16'h00AB), "midf");

    do_reset();
    minit();
    begin
      int hcnt;
      logic [15:0] ea;
      logic [7:0] dbi, dbo, acc;
      logic we;
      hcnt = 0;
      for (int it = 0; it < 1500; it++) begin
        @(negedge clk);
        reset = ($urandom_range(0, 79) == 0) || (hcnt > 3);
        bus.s_ab = 3'($urandom_range(0, 7));
        bus.s_db = 4'($urandom_range(0, 13));
        bus.t_db = 4'($urandom_range(0, 13));
        bus.use_alu = 1'($urandom_range(0, 1));
        bus.s_acc = 2'($urandom_range(0, 3));
        bus.idu = 1'($urandom_range(0, 1));
        bus.wr_pc = 1'($urandom_range(0, 1));
        bus.write_mem = ($urandom_range(0, 3) == 0);
        bus.done = (mstep >= 5) ? ($urandom_range(0, 1) == 1)
                                : ($urandom_range(0, 6) == 0);
        bus.is_cond = ($urandom_range(0, 3) == 0);
        bus.cond_met = 1'($urandom_range(0, 1));
        bus.next_cond = 3'($urandom_range(0, 7));
        bus.mem_rdata = 8'($urandom);
        bus.alu_result = 8'($urandom);
        bus.mem_ready = ($urandom_range(0, 3) != 0);
        #1;
        ea = m_addr(bus.s_ab);
        dbi = m_db(bus.s_db, bus.mem_rdata);
        dbo = bus.use_alu ? bus.alu_result : dbi;
        we = (mmode == 1) && (bus.write_mem ||
             (bus.t_db == R_MEM && bus.s_db != R_MEM));
        case (bus.s_acc)
          2'd0: acc = mr[0];
          2'd1: acc = msp[7:0];
          2'd2: acc = msp[15:8];
          default: acc = mpc[7:0];
        endcase
        chk("rnd addr", bus.mem_addr, ea);
        chk("rnd we", {15'h0, bus.mem_we}, {15'h0, we});
        chk("rnd wdata", {8'h00, bus.mem_wdata}, {8'h00, dbi});
        chk("rnd alu_a", {8'h00, bus.alu_a}, {8'h00, acc});
        @(posedge clk);
        if (reset) begin
          minit();
        end else if (bus.mem_ready) begin
          if (mmode == 0) begin
            mir = bus.mem_rdata;
            mpc = mpc + 16'd1;
            mstep = 0;
            mmode = 1;
          end else if (mmode == 1) begin
            if (bus.t_db != R_MEM && !we) m_write(bus.t_db, dbo);
            if (bus.wr_pc) mpc = bus.idu ? ea - 16'd1 : ea + 16'd1;
            if (bus.done) begin
              mir = bus.mem_rdata;
              mstep = 0;
            end else if (bus.is_cond && !bus.cond_met) begin
              mstep = int'(bus.next_cond);
            end else if (mstep == 7) begin
              mmode = 2;
              mhalt = 1'b1;
            end else begin
              mstep = mstep + 1;
            end
          end
        end
        hcnt = (mmode == 2) ? hcnt + 1 : 0;
        #1;
        chk("rnd step", {13'h0, bus.step}, 16'(mstep));
        chk("rnd opcode", {8'h00, bus.opcode}, {8'h00, mir});
        chk("rnd halted", {15'h0, bus.halted}, {15'h0, mhalt});
      end
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Execution end of the SM83 micro-op interface. Holds IR, the step counter and the register file.
- Consumes the per-step control word from `decoder` and returns `opcode`/`step` to it.
- Drives the address bus mux, data bus mux, IDU and external memory port.
- Sits between `decoder`, an external ALU/flag unit and the memory bus.
- One step = one M-cycle = one clk edge, unless memory stalls.

Parameters:
- RESET_PC, 16'h0000, PC value after reset.
- RESET_SP, 16'hFFFE, SP value after reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  out  8 (opcode_t)  current IR, to decoder.
- step  out  3  current step, to decoder.
- done  in  1  decoder: last step; latch IR from memory, step <= 0.
- is_cond  in  1  decoder: branch on cond_met this step.
- next_cond  in  3  decoder: step target when condition fails.
- s_ab  in  3 (reg16_t)  decoder: address bus source.
- s_db  in  4 (reg8_t)  decoder: data bus source (MEM = mem_rdata).
- t_db  in  4 (reg8_t)  decoder: data bus target (MEM = no register write).
- use_alu  in  1  decoder: db_out = alu_result.
- s_acc  in  2 (s_acc_t)  decoder: ALU accumulator source.
- idu  in  1 (idu_mode_t)  decoder: INC/DEC.
- wr_pc  in  1  decoder: PC <= IDU out.
- write_mem  in  1  decoder: external write request.
- cond_met  in  1  flag unit: current cc satisfied.
- alu_a  out  8  ALU accumulator operand.
- alu_b  out  8  ALU second operand (= db_in).
- alu_result  in  8  ALU combinational result.
- mem_addr  out  16  address bus.
- mem_wdata  out  8  write data.
- mem_we  out  1  write strobe.
- mem_rdata  in  8  read data, valid combinationally while mem_ready.
- mem_ready  in  1  0 = stall current step.
- halted  out  1  sticky fault: step overran.

Behaviour:
- FSM states: FETCH, EXEC, HALT.
  - Reset -> FETCH.
  - FETCH: mem_addr=PC, mem_we=0. When mem_ready: IR<=mem_rdata, PC<=PC+1, step<=0, -> EXEC.
  - HALT: mem_we=0, mem_addr=PC, no state changes; only reset exits.
- Reset values:
  - Registers: PC=RESET_PC, SP=RESET_SP, IR=8'h00, step=0, halted=0.
  - A,B,C,D,E,H,L,W,Z all 8'h00.
  - Outputs: mem_we=0, mem_addr=RESET_PC.
- Address bus (EXEC):
  - mem_addr = {W,Z}/BC/DE/HL/SP/PC per s_ab.
  - Any other s_ab value selects PC.
  - Always uses pre-edge register values.
- Data bus:
  - db_in = mem_rdata if s_db==MEM, else the selected 8-bit register (PCH/PCL/SPH/SPL map to PC/SP bytes).
  - db_out = use_alu ? alu_result : db_in.
- ALU operands:
  - alu_b = db_in.
  - alu_a = A (ACC_DB), SPL, SPH or PCL per s_acc.
- Writes:
  - mem_we = write_mem | (t_db==MEM & s_db!=MEM); mem_wdata = db_in.
  - Register write of db_out into t_db occurs iff t_db!=MEM and mem_we==0.
- IDU:
  - idu_out = mem_addr+1 (INC) or mem_addr-1 (DEC), 16-bit wrap (16'hFFFF+1=16'h0000, 16'h0000-1=16'hFFFF).
  - When wr_pc, PC<=idu_out.
  - If t_db is PCH/PCL in the same step, the wr_pc result wins for PC.
- Step advance (EXEC, mem_ready=1):
  - done: IR<=mem_rdata and step<=0, with the PC increment driven by the decoder.
  - is_cond & !cond_met: step<=next_cond.
  - Otherwise: step<=step+1.
  - step==7 with no done and no taken next_cond: -> HALT, halted<=1, no register/PC write that cycle beyond the normal one.
- Stall: mem_ready=0 blocks all updates (IR, step, registers, PC). mem_we is held asserted with stable addr/data until ready.
- done & is_cond together: done has priority.
- Reset asserted mid-instruction: next edge restores all reset values regardless of state or mem_ready.

Test Plan:
- Reset then mem returns 8'h3E at 0x0000 and 8'h5A at 0x0001 (LD A,n):
  - FETCH reads 0x0000, IR=3E; step0 addr=0x0001, Z=5A.
  - step1: A=5A, IR<=[0x0002], PC=0x0003.
- Preload HL=0xC000, A=0x77, IR=0x77 (LD [HL],A):
  - step0: mem_addr=0xC000, mem_we=1, wdata=0x77.
  - step1: fetch at PC, done.
- LD_NN_A step2 (t_db=MEM, s_db=A, write_mem=0), WZ=0xD123:
  - mem_we=1, addr=0xD123.
  - No register changes.
- mem_ready held low 3 cycles during an EXEC step:
  - step, PC and registers unchanged; mem_we stable.
  - Completes on the first ready cycle.
- Forced is_cond=1, cond_met=0, next_cond=5 at step 1 -> step=5. With cond_met=1 -> step=2.
- PC=0xFFFF, wr_pc INC -> PC=0x0000.
- Decoder forced done=0 through step 7 -> halted=1, no further mem_we.
- Reset mid-step 2 -> PC=0x0000, SP=0xFFFE, state FETCH.
